random_arbiter: RTL

RANDOM_ARBITER -- requirements
Module: random_arbiter

---
 rtl/random_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/random_arbiter.sv
// rtl/random_arbiter.sv - round-robin arbiter handing out bounded pseudo-random draws
//
// Purpose:
//   Requesters share one free-running 4-bit random source. The arbiter picks an
//   owner round-robin. It then samples rand_in until the value falls under the
//   owner's bound. If the bound rejects MAX_TRIES samples in a row, the owner
//   gets a fallback grant with value 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   rand_in   in   [3:0]        current LFSR value, advances every clk
//   req       in   [N_REQ-1:0]  level requests, held until granted
//   bound     in   [4*N_REQ-1:0] per-requester upper bound, 0 = unbounded
//   gnt       out  [N_REQ-1:0]  one-hot single-cycle grant pulse
//   rand_val  out  [3:0]        delivered value, held until the next grant
//   rand_fb   out  1            delivered value is a fallback (forced 0)
//   busy      out  1            arbiter is not idle

module random_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_TRIES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         rand_in,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] bound,
  output logic [N_REQ-1:0]   gnt,
  output logic [3:0]         rand_val,
  output logic               rand_fb,
  output logic               busy
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, SAMPLE, GRANT} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_owner_q, last_owner_d;
  logic [3:0]        tries_q, tries_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [3:0]        rand_val_q, rand_val_d;
  logic              rand_fb_q, rand_fb_d;

  logic [OW-1:0]     rr_pick;
  logic [OW-1:0]     cand;
  logic [3:0]        owner_bound;
  logic              accept;

  // Round-robin pick starting one past the last owner. Walking the offsets from
  // farthest to nearest lets the nearest requesting index overwrite the others.
  always_comb begin
    rr_pick = last_owner_q;
    cand    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = OW'((int'(last_owner_q) + off) % N_REQ);
      if (req[cand]) rr_pick = cand;
    end
  end

  // The owner's bound is read live every SAMPLE cycle.
  assign owner_bound = bound[{owner_q, 2'b00} +: 4];
  assign accept      = (owner_bound == 4'd0) || (rand_in < owner_bound);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tries_d      = tries_q;
    gnt_d        = '0;
    rand_val_d   = rand_val_q;
    rand_fb_d    = rand_fb_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = rr_pick;
          tries_d = 4'd0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (!req[owner_q]) begin
          // The owner withdrew, so drop the transaction and leave history untouched.
          state_d = IDLE;
        end else if (accept) begin
          rand_val_d   = rand_in;
          rand_fb_d    = 1'b0;
          gnt_d        = N_REQ'(1) << owner_q;
          last_owner_d = owner_q;
          state_d      = GRANT;
        end else if (tries_q == 4'(MAX_TRIES - 1)) begin
          rand_val_d   = 4'd0;
          rand_fb_d    = 1'b1;
          gnt_d        = N_REQ'(1) << owner_q;
          last_owner_d = owner_q;
          state_d      = GRANT;
        end else begin
          tries_d = tries_q + 4'd1;
        end
      end
      GRANT: begin
        // Spacer cycle so that consecutive grants never share a rand_in sample.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(N_REQ - 1);
      tries_q      <= 4'd0;
      gnt_q        <= '0;
      rand_val_q   <= 4'd0;
      rand_fb_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tries_q      <= tries_d;
      gnt_q        <= gnt_d;
      rand_val_q   <= rand_val_d;
      rand_fb_q    <= rand_fb_d;
    end
  end

  assign gnt      = gnt_q;
  assign rand_val = rand_val_q;
  assign rand_fb  = rand_fb_q;
  assign busy     = (state_q != IDLE);

endmodule
